// File: rtl/cmp_event_monitor_pkg.sv
// Shared types and helpers for the comparator event monitor.
// Defines the 2-bit relation encoding and the decode of the comparator's
// three relation flags into a relation plus a well-formed bit.
package cmp_mon_pkg;

    // Stable-relation encoding, also used as the event code.
    typedef enum logic [1:0] {
        UNKNOWN = 2'b00,
        LESS    = 2'b01,
        EQUAL   = 2'b10,
        GREATER = 2'b11
    } rel_t;

    // Result of a flag decode: ok is low when the flag set is malformed.
    typedef struct packed {
        logic ok;
        rel_t rel;
    } flag_dec_t;

    // Width of the debounce run counter; PERSIST is limited to 1..15.
    localparam int RUN_W = 4;

    // Exactly one flag must be high; anything else is malformed.
    function automatic flag_dec_t decodeFlags(input logic aeqb,
                                              input logic agrtb,
                                              input logic alessb);
        flag_dec_t d;
        d.ok  = 1'b0;
        d.rel = UNKNOWN;
        case ({aeqb, agrtb, alessb})
            3'b100:  begin d.ok = 1'b1; d.rel = EQUAL;   end
            3'b010:  begin d.ok = 1'b1; d.rel = GREATER; end
            3'b001:  begin d.ok = 1'b1; d.rel = LESS;    end
            default: begin d.ok = 1'b0; d.rel = UNKNOWN; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cmp_event_monitor_if.sv
// Bundle of the monitor's sample input, event handshake and status outputs.
// master: the side feeding comparator samples and consuming events.
// slave:  the monitor itself.
interface cmp_event_monitor_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] diff;
    logic             aeqb;
    logic             agrtb;
    logic             alessb;
    logic             clear;
    logic [1:0]       state;
    logic             evt_valid;
    logic             evt_ready;
    logic [1:0]       evt_code;
    logic [CNT_W-1:0] evt_stamp;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [WIDTH-1:0] max_gt_diff;
    logic             err;
    logic             evt_ovf;

    modport master (
        output in_valid, diff, aeqb, agrtb, alessb, clear, evt_ready,
        input  state, evt_valid, evt_code, evt_stamp,
               eq_cnt, gt_cnt, lt_cnt, max_gt_diff, err, evt_ovf
    );

    modport slave (
        input  in_valid, diff, aeqb, agrtb, alessb, clear, evt_ready,
        output state, evt_valid, evt_code, evt_stamp,
               eq_cnt, gt_cnt, lt_cnt, max_gt_diff, err, evt_ovf
    );
endinterface

// File: rtl/cmp_event_monitor_evt_slot.sv
// cmp_evt_slot: one-entry valid/ready holding register for state-change
// events. A new event loads when the slot is empty or being drained this
// cycle; otherwise it is dropped and the sticky overflow flag is raised.
module cmp_evt_slot #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [1:0]       loadCode,
    input  logic [CNT_W-1:0] loadStamp,
    input  logic             evtReady,
    output logic             evtValid,
    output logic [1:0]       evtCode,
    output logic [CNT_W-1:0] evtStamp,
    output logic             evtOvf
);
    logic canLoad;

    assign canLoad = !evtValid || evtReady;

    // Slot register: load, drain on handshake, or record a dropped event.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so ordering of statements cannot create races.
        if (rst) begin
            evtValid <= 1'b0;
            evtCode  <= '0;
            evtStamp <= '0;
            evtOvf   <= 1'b0;
        end else if (clear) begin
            evtValid <= 1'b0;
            evtCode  <= '0;
            evtStamp <= '0;
            evtOvf   <= 1'b0;
        end else begin
            if (load && canLoad) begin
                evtValid <= 1'b1;
                evtCode  <= loadCode;
                evtStamp <= loadStamp;
            end else if (evtValid && evtReady) begin
                evtValid <= 1'b0;
            end
            if (load && !canLoad) begin
                evtOvf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmp_event_monitor.sv
// cmp_event_monitor: debounces the comparator's relation flags into a stable
// relation state, emits an event on each stable change and tracks sticky
// error/overflow flags. Optional relation statistics are built only when the
// macro CMP_MON_STATS_EN is defined; otherwise those outputs read as zero.
module cmp_event_monitor #(
    parameter int WIDTH   = 4,
    parameter int PERSIST = 3,
    parameter int CNT_W   = 8
) (
    input logic              clk,
    input logic              rst,
    cmp_event_monitor_if.slave bus
);
    import cmp_mon_pkg::*;

    localparam logic [RUN_W-1:0] PERSIST_V = RUN_W'(PERSIST);

    rel_t             stateQ, stateD;
    rel_t             candQ, candD;
    logic [RUN_W-1:0] runQ, runD;
    logic [CNT_W-1:0] sampleIdx;
    logic             errQ;
    logic             fire;
    flag_dec_t        dec;
    logic             accept;
    logic             goodSample;
    logic             badSample;

    assign dec        = decodeFlags(bus.aeqb, bus.agrtb, bus.alessb);
    assign accept     = bus.in_valid && !bus.clear;
    assign goodSample = accept && dec.ok;
    assign badSample  = accept && !dec.ok;

    // Debounce next-state: extend or restart the run, switch state at PERSIST.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        stateD = stateQ;
        candD  = candQ;
        runD   = runQ;
        fire   = 1'b0;
        if (goodSample) begin
            if (dec.rel == candQ) begin
                runD = (runQ >= PERSIST_V) ? PERSIST_V : runQ + 1'b1;
            end else begin
                candD = dec.rel;
                runD  = RUN_W'(1);
            end
            if (runD == PERSIST_V && candD != stateQ) begin
                stateD = candD;
                fire   = 1'b1;
            end
        end
    end

    // Debounce state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= UNKNOWN;
            candQ  <= UNKNOWN;
            runQ   <= '0;
        end else if (bus.clear) begin
            stateQ <= UNKNOWN;
            candQ  <= UNKNOWN;
            runQ   <= '0;
        end else begin
            stateQ <= stateD;
            candQ  <= candD;
            runQ   <= runD;
        end
    end

    // Sample index (wraps) and sticky malformed-flag error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sampleIdx <= '0;
            errQ      <= 1'b0;
        end else if (bus.clear) begin
            sampleIdx <= '0;
            errQ      <= 1'b0;
        end else begin
            if (goodSample) sampleIdx <= sampleIdx + 1'b1;
            if (badSample)  errQ      <= 1'b1;
        end
    end

    // The stamp is the index of the sample that caused the change.
    cmp_evt_slot #(.CNT_W(CNT_W)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.clear),
        .load      (fire),
        .loadCode  (stateD),
        .loadStamp (sampleIdx),
        .evtReady  (bus.evt_ready),
        .evtValid  (bus.evt_valid),
        .evtCode   (bus.evt_code),
        .evtStamp  (bus.evt_stamp),
        .evtOvf    (bus.evt_ovf)
    );

    assign bus.state = stateQ;
    assign bus.err   = errQ;

`ifdef CMP_MON_STATS_EN
    logic [CNT_W-1:0] eqCnt, gtCnt, ltCnt;
    logic [WIDTH-1:0] maxGtDiff;

    // Saturating per-relation counters and running maximum of GREATER diffs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eqCnt     <= '0;
            gtCnt     <= '0;
            ltCnt     <= '0;
            maxGtDiff <= '0;
        end else if (bus.clear) begin
            eqCnt     <= '0;
            gtCnt     <= '0;
            ltCnt     <= '0;
            maxGtDiff <= '0;
        end else if (goodSample) begin
            case (dec.rel)
                EQUAL:   if (eqCnt != '1) eqCnt <= eqCnt + 1'b1;
                LESS:    if (ltCnt != '1) ltCnt <= ltCnt + 1'b1;
                GREATER: begin
                    if (gtCnt != '1) gtCnt <= gtCnt + 1'b1;
                    if (bus.diff > maxGtDiff) maxGtDiff <= bus.diff;
                end
                default: ;
            endcase
        end
    end

    assign bus.eq_cnt      = eqCnt;
    assign bus.gt_cnt      = gtCnt;
    assign bus.lt_cnt      = ltCnt;
    assign bus.max_gt_diff = maxGtDiff;
`else
    // Statistics not built: the difference word has no consumer.
    logic unusedDiff;
    assign unusedDiff      = ^bus.diff;
    assign bus.eq_cnt      = '0;
    assign bus.gt_cnt      = '0;
    assign bus.lt_cnt      = '0;
    assign bus.max_gt_diff = '0;
`endif

endmodule

// File: tb/tb_cmp_event_monitor.sv
// Directed bench for cmp_event_monitor (PERSIST=3, CNT_W=8). Expected events
// are queued as stimulus is issued and compared when drained from the slot.
// Statistics expectations follow CMP_MON_STATS_EN (zero when undefined).
module tb_cmp_event_monitor;
    import cmp_mon_pkg::*;

    localparam int WIDTH   = 4;
    localparam int PERSIST = 3;
    localparam int CNT_W   = 8;

    typedef struct {
        logic [1:0]       code;
        logic [CNT_W-1:0] stamp;
    } evt_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cmp_event_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    cmp_event_monitor #(.WIDTH(WIDTH), .PERSIST(PERSIST), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         nAssert = 0;
    int         nFail   = 0;
    evt_t       expQ[$];
    int         expEq, expGt, expLt;
    logic [WIDTH-1:0] expMax;

    function automatic int sx(input int v);
`ifdef CMP_MON_STATS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        expEq  = 0;
        expGt  = 0;
        expLt  = 0;
        expMax = '0;
    endtask

    // One accepted sample at the next rising edge; outputs checked #1 after it.
    task automatic sample(input logic e, input logic g, input logic l, input logic [WIDTH-1:0] d);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.aeqb     = e;
        bus.agrtb    = g;
        bus.alessb   = l;
        bus.diff     = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.aeqb     = 1'b0;
        bus.agrtb    = 1'b0;
        bus.alessb   = 1'b0;
        bus.diff     = '0;
        if ($onehot({e, g, l})) begin
            if (e && expEq < 255) expEq++;
            if (l && expLt < 255) expLt++;
            if (g) begin
                if (expGt < 255) expGt++;
                if (d > expMax) expMax = d;
            end
        end
    endtask

    task automatic expectEvt(input logic [1:0] code, input logic [CNT_W-1:0] stamp);
        evt_t e;
        e.code  = code;
        e.stamp = stamp;
        expQ.push_back(e);
    endtask

    // Compare the pending event with the oldest expectation, then accept it.
    task automatic popEvent(input string tag);
        evt_t e;
        check({tag, "_queued"}, 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check({tag, "_valid"}, 32'(bus.evt_valid), 32'd1);
            check({tag, "_code"},  32'(bus.evt_code),  32'(e.code));
            check({tag, "_stamp"}, 32'(bus.evt_stamp), 32'(e.stamp));
        end
        @(negedge clk);
        bus.evt_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.evt_ready = 1'b0;
        check({tag, "_drained"}, 32'(bus.evt_valid), 32'd0);
    endtask

    task automatic checkStats(input string tag);
        check({tag, "_eq_cnt"},      32'(bus.eq_cnt),      32'(sx(expEq)));
        check({tag, "_gt_cnt"},      32'(bus.gt_cnt),      32'(sx(expGt)));
        check({tag, "_lt_cnt"},      32'(bus.lt_cnt),      32'(sx(expLt)));
        check({tag, "_max_gt_diff"}, 32'(bus.max_gt_diff), 32'(sx(int'(expMax))));
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_state"},     32'(bus.state),     32'd0);
        check({tag, "_evt_valid"}, 32'(bus.evt_valid), 32'd0);
        check({tag, "_evt_code"},  32'(bus.evt_code),  32'd0);
        check({tag, "_evt_stamp"}, 32'(bus.evt_stamp), 32'd0);
        check({tag, "_err"},       32'(bus.err),       32'd0);
        check({tag, "_evt_ovf"},   32'(bus.evt_ovf),   32'd0);
        checkStats(tag);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.diff      = '0;
        bus.aeqb      = 1'b0;
        bus.agrtb     = 1'b0;
        bus.alessb    = 1'b0;
        bus.clear     = 1'b0;
        bus.evt_ready = 1'b0;
        modelClear();
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Three GREATER samples: state switches only after the third.
        sample(1'b0, 1'b1, 1'b0, 4'd2);
        sample(1'b0, 1'b1, 1'b0, 4'd5);
        check("gt_run2_state", 32'(bus.state), 32'(UNKNOWN));
        check("gt_run2_valid", 32'(bus.evt_valid), 32'd0);
        expectEvt(GREATER, 8'd2);
        sample(1'b0, 1'b1, 1'b0, 4'd3);
        check("gt_state", 32'(bus.state), 32'(GREATER));
        popEvent("gt_event");
        checkStats("gt");

        // Alternating LESS/EQUAL never reaches PERSIST (indices 3..12).
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) sample(1'b0, 1'b0, 1'b1, 4'd0);
            else            sample(1'b1, 1'b0, 1'b0, 4'd0);
        end
        check("alt_state", 32'(bus.state), 32'(GREATER));
        check("alt_valid", 32'(bus.evt_valid), 32'd0);
        checkStats("alt");

        // LESS event held with ready low; the following EQUAL event drops.
        expectEvt(LESS, 8'd15);
        repeat (3) sample(1'b0, 1'b0, 1'b1, 4'd0);
        check("less_state", 32'(bus.state), 32'(LESS));
        repeat (3) sample(1'b1, 1'b0, 1'b0, 4'd0);
        check("ovf_state", 32'(bus.state), 32'(EQUAL));
        check("ovf_flag", 32'(bus.evt_ovf), 32'd1);
        popEvent("held_event");
        checkStats("ovf");

        // GREATER again, then an EQUAL run interrupted by a malformed sample.
        expectEvt(GREATER, 8'd21);
        sample(1'b0, 1'b1, 1'b0, 4'd1);
        sample(1'b0, 1'b1, 1'b0, 4'd9);
        sample(1'b0, 1'b1, 1'b0, 4'd4);
        popEvent("gt2_event");
        sample(1'b1, 1'b0, 1'b0, 4'd0);
        sample(1'b1, 1'b1, 1'b0, 4'd0);
        check("bad_err", 32'(bus.err), 32'd1);
        checkStats("bad");
        sample(1'b1, 1'b0, 1'b0, 4'd0);
        check("bad_run2_state", 32'(bus.state), 32'(GREATER));
        expectEvt(EQUAL, 8'd24);
        sample(1'b1, 1'b0, 1'b0, 4'd0);
        check("bad_run3_state", 32'(bus.state), 32'(EQUAL));
        popEvent("eq_after_bad");

        // Clear with a same-cycle sample: the sample is discarded.
        @(negedge clk);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.agrtb    = 1'b1;
        bus.diff     = 4'd15;
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.agrtb    = 1'b0;
        bus.diff     = '0;
        modelClear();
        checkAllZero("clear");

        // 260 EQUAL samples: counter saturates, index wraps to 4.
        expectEvt(EQUAL, 8'd2);
        repeat (260) sample(1'b1, 1'b0, 1'b0, 4'd0);
        check("sat_state", 32'(bus.state), 32'(EQUAL));
        popEvent("sat_event");
        checkStats("sat");
        expectEvt(GREATER, 8'd6);
        repeat (3) sample(1'b0, 1'b1, 1'b0, 4'd7);
        popEvent("wrap_event");
        checkStats("wrap");

        // Reset while an event is pending and an EQUAL run is at 2.
        repeat (3) sample(1'b0, 1'b0, 1'b1, 4'd0);
        repeat (2) sample(1'b1, 1'b0, 1'b0, 4'd0);
        check("prerst_valid", 32'(bus.evt_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #2;
        modelClear();
        checkAllZero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) sample(1'b1, 1'b0, 1'b0, 4'd0);
        check("postrst_run2_state", 32'(bus.state), 32'(UNKNOWN));
        check("postrst_run2_valid", 32'(bus.evt_valid), 32'd0);
        expectEvt(EQUAL, 8'd2);
        sample(1'b1, 1'b0, 1'b0, 4'd0);
        popEvent("postrst_event");
        check("queue_empty", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
